memory_array_ctrl: RTL and testbench

- Parametrised successor to the 8-bit single-row memory: a WIDTH x DEPTH word-addressed storage array with a sequential access controller.
- Adds a clock, a req/ready/done handshake, row addressing, a post-reset clearing sweep and registered read data.
- Sits between the bus-side controller and the array; one access in flight at a time.

---
 rtl/memory_array_ctrl_if.sv | 32 +++
 rtl/memory_array_ctrl.sv | 121 ++++++++++++
 tb/tb_memory_array_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_array_ctrl_if.sv
// rtl/memory_array_ctrl_if.sv - request/response bundle between bus-side controller and memory_array_ctrl
//
// Signals (master = bus-side controller, slave = memory_array_ctrl):
//   req        master->slave  access request, sampled while ready=1
//   op         master->slave  1=write, 0=read
//   addr       master->slave  row address [ADDR_W]
//   data_in    master->slave  write data [WIDTH]
//   ready      slave->master  controller idle, request can be accepted
//   done       slave->master  one-cycle completion pulse
//   data_out   slave->master  registered read data [WIDTH]
//   parity_err slave->master  read parity mismatch (only with MEMORY_ARRAY_PARITY_EN)
interface memory_array_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic              req;
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data_in;
    logic              ready;
    logic              done;
    logic [WIDTH-1:0]  data_out;
`ifdef MEMORY_ARRAY_PARITY_EN
    logic              parity_err;

    modport master (output req, op, addr, data_in, input ready, done, data_out, parity_err);
    modport slave  (input req, op, addr, data_in, output ready, done, data_out, parity_err);
`else
    modport master (output req, op, addr, data_in, input ready, done, data_out);
    modport slave  (input req, op, addr, data_in, output ready, done, data_out);
`endif
endinterface

// File: rtl/memory_array_ctrl.sv
// rtl/memory_array_ctrl.sv - WIDTH x DEPTH storage array with sequential access controller
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    memory_array_ctrl_if.slave (req/op/addr/data_in in; ready/done/data_out out)
// Optional feature macro: MEMORY_ARRAY_PARITY_EN adds a stored even-parity bit per row
// and drives bus.parity_err in the DONE cycle of a read.
module memory_array_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    memory_array_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACCESS, S_DONE} state_t;

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;
    logic              lat_op;
    logic [ADDR_W-1:0] lat_addr;
    logic [WIDTH-1:0]  lat_data;
    logic [WIDTH-1:0]  data_out_q;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              in_range;

    assign in_range = ({1'b0, lat_addr} < DEPTH_W);

`ifdef MEMORY_ARRAY_PARITY_EN
    logic par_mem [DEPTH];
    logic parity_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_INIT:   if (ptr == LAST_ROW) next_state = S_IDLE;
            S_IDLE:   if (bus.req) next_state = S_ACCESS;
            S_ACCESS: next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_INIT;
        endcase
    end

    always_comb begin
        bus.ready = (state == S_IDLE);
        bus.done  = (state == S_DONE);
    end

    assign bus.data_out = data_out_q;

    // Sweep pointer, request capture and registered read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr        <= '0;
            lat_op     <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
            data_out_q <= '0;
        end else begin
            if (state == S_INIT) begin
                ptr <= ptr + ADDR_W'(1);
            end
            if (state == S_IDLE && bus.req) begin
                lat_op   <= bus.op;
                lat_addr <= bus.addr;
                lat_data <= bus.data_in;
            end
            if (state == S_ACCESS && !lat_op) begin
                data_out_q <= in_range ? mem[lat_addr] : '0;
            end
        end
    end

    // Array storage has no reset of its own; the INIT sweep establishes its contents,
    // and a write still latched when reset hits is simply never performed.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == S_INIT) begin
                mem[ptr] <= '0;
`ifdef MEMORY_ARRAY_PARITY_EN
                par_mem[ptr] <= 1'b0;
`endif
            end else if (state == S_ACCESS && lat_op && in_range) begin
                mem[lat_addr] <= lat_data;
`ifdef MEMORY_ARRAY_PARITY_EN
                par_mem[lat_addr] <= ^lat_data;
`endif
            end
        end
    end

`ifdef MEMORY_ARRAY_PARITY_EN
    // Loaded at the ACCESS exit edge, so it is only ever high in the DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= (state == S_ACCESS) && !lat_op && in_range &&
                            ((^mem[lat_addr]) != par_mem[lat_addr]);
        end
    end

    assign bus.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_memory_array_ctrl.sv
// tb/tb_memory_array_ctrl.sv - scoreboard testbench for memory_array_ctrl
module tb_memory_array_ctrl;
    localparam int WIDTH   = 8;
    localparam int ADDR_W  = 4;
    localparam int DEPTH_A = 16;
    localparam int DEPTH_B = 12;

    typedef struct {
        logic             is_read;
        logic [WIDTH-1:0] data;
        logic             perr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req;
    logic              op;
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  din;
    logic              rdy;
    logic              dn;
    logic [WIDTH-1:0]  dout;
    logic              exp_perr;

    logic [WIDTH-1:0]  mdl_a [16];
    logic [WIDTH-1:0]  mdl_b [16];
    exp_t              sb [$];
    int                n_checks = 0;
    int                n_fail   = 0;

    always #5 clk = ~clk;

    memory_array_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus_a ();
    memory_array_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus_b ();

    assign bus_a.req     = req & ~sel;
    assign bus_a.op      = op;
    assign bus_a.addr    = addr;
    assign bus_a.data_in = din;
    assign bus_b.req     = req & sel;
    assign bus_b.op      = op;
    assign bus_b.addr    = addr;
    assign bus_b.data_in = din;

    assign rdy  = sel ? bus_b.ready    : bus_a.ready;
    assign dn   = sel ? bus_b.done     : bus_a.done;
    assign dout = sel ? bus_b.data_out : bus_a.data_out;
`ifdef MEMORY_ARRAY_PARITY_EN
    logic perr;
    assign perr = sel ? bus_b.parity_err : bus_a.parity_err;
`endif

    memory_array_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH_A), .ADDR_W(ADDR_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    memory_array_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH_B), .ADDR_W(ADDR_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    function automatic logic [WIDTH-1:0] model_read(input bit s, input logic [ADDR_W-1:0] a);
        if (s) return (int'(a) < DEPTH_B) ? mdl_b[a] : '0;
        return mdl_a[a];
    endfunction

    task automatic model_write(input bit s, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        if (s) begin
            if (int'(a) < DEPTH_B) mdl_b[a] = d;
        end else begin
            mdl_a[a] = d;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            mdl_a[i] = '0;
            mdl_b[i] = '0;
        end
    endtask

    // One complete access; expectation pushed at the accept edge, popped in the done cycle.
    task automatic do_access(input bit s, input bit o, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        exp_t e;
        int   w;
        @(negedge clk);
        sel = s; op = o; addr = a; din = d; req = 1'b1;
        w = 0;
        while (rdy !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: ready=%b required 1", rdy);
            req = 1'b0;
            return;
        end
        e.is_read = !o;
        e.data    = o ? dout : model_read(s, a);
        e.perr    = o ? 1'b0 : exp_perr;
        if (o) model_write(s, a, d);
        sb.push_back(e);
        @(negedge clk);
        req = 1'b0;
        n_checks++;
        if (dn !== 1'b0) begin
            n_fail++;
            $display("FAIL done_early: done=%b required 0 (addr %0d)", dn, a);
        end
        @(negedge clk);
        n_checks++;
        if (dn !== 1'b1) begin
            n_fail++;
            $display("FAIL done_latency: done=%b required 1 (addr %0d)", dn, a);
        end
        e = sb.pop_front();
        n_checks++;
        if (dout !== e.data) begin
            n_fail++;
            $display("FAIL data_out: op=%0d addr=%0d got %h required %h", o, a, dout, e.data);
        end
`ifdef MEMORY_ARRAY_PARITY_EN
        n_checks++;
        if (perr !== e.perr) begin
            n_fail++;
            $display("FAIL parity_err: addr=%0d got %b required %b", a, perr, e.perr);
        end
`endif
        @(negedge clk);
        n_checks++;
        if (dn !== 1'b0 || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL done_release: done=%b ready=%b required 0/1", dn, rdy);
        end
    endtask

    // Counts INIT cycles of DUT A from the current negedge; done/data_out must stay 0.
    task automatic count_init(output int cnt);
        int bad;
        cnt = 0;
        bad = 0;
        while (bus_a.ready !== 1'b1 && cnt < 40) begin
            if (bus_a.done !== 1'b0 || bus_a.data_out !== '0) bad++;
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt != DEPTH_A) begin
            n_fail++;
            $display("FAIL init_length: %0d cycles with ready=0, required %0d", cnt, DEPTH_A);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL init_outputs: %0d cycles with done/data_out nonzero, required 0", bad);
        end
    endtask

    task automatic test_reset();
        int cnt;
        req = 1'b0; sel = 1'b0; op = 1'b0; addr = '0; din = '0; exp_perr = 1'b0;
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus_a.ready !== 1'b0 || bus_a.done !== 1'b0 || bus_a.data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b done=%b data_out=%h required 0/0/00",
                     bus_a.ready, bus_a.done, bus_a.data_out);
        end
        rst_n = 1'b1;
        count_init(cnt);
        n_checks++;
        if (bus_b.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL init_b_ready: ready=%b required 1", bus_b.ready);
        end
        for (int i = 0; i < DEPTH_A; i++) do_access(1'b0, 1'b0, ADDR_W'(i), '0);
    endtask

    task automatic test_write_read();
        do_access(1'b0, 1'b1, 4'd3, 8'hA5);
        do_access(1'b0, 1'b0, 4'd3, 8'h00);
        @(negedge clk);
        n_checks++;
        if (dout !== 8'hA5) begin
            n_fail++;
            $display("FAIL data_out_hold: got %h required a5", dout);
        end
        do_access(1'b0, 1'b1, 4'd9, 8'h3C);
        do_access(1'b0, 1'b0, 4'd9, 8'h00);
    endtask

    task automatic test_back_to_back();
        logic             o_t [4];
        logic [ADDR_W-1:0] a_t [4];
        logic [WIDTH-1:0] d_t [4];
        exp_t             e;
        int               idx, last_acc, dones;
        bit               advance;
        o_t = '{1'b1, 1'b1, 1'b0, 1'b0};
        a_t = '{4'd0, 4'd15, 4'd0, 4'd15};
        d_t = '{8'h11, 8'h22, 8'h00, 8'h00};
        @(negedge clk);
        sel = 1'b0; idx = 0; last_acc = -1; dones = 0; advance = 1'b0;
        op = o_t[0]; addr = a_t[0]; din = d_t[0]; req = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (advance) begin
                advance = 1'b0;
                if (idx < 4) begin
                    op = o_t[idx]; addr = a_t[idx]; din = d_t[idx];
                end else begin
                    req = 1'b0;
                end
            end
            if (dn === 1'b1) begin
                dones++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    n_checks++;
                    if (dout !== e.data) begin
                        n_fail++;
                        $display("FAIL b2b_data: got %h required %h", dout, e.data);
                    end
                end
            end
            if (req === 1'b1 && rdy === 1'b1) begin
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != 3) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: %0d cycles between accepts, required 3", cyc - last_acc);
                    end
                end
                last_acc  = cyc;
                e.is_read = !o_t[idx];
                e.data    = o_t[idx] ? dout : model_read(1'b0, a_t[idx]);
                e.perr    = 1'b0;
                if (o_t[idx]) model_write(1'b0, a_t[idx], d_t[idx]);
                sb.push_back(e);
                idx++;
                advance = 1'b1;
            end
            if (idx == 4 && sb.size() == 0 && !advance) break;
            @(negedge clk);
        end
        req = 1'b0;
        n_checks++;
        if (idx != 4 || dones != 4) begin
            n_fail++;
            $display("FAIL b2b_count: accepts=%0d dones=%0d required 4/4", idx, dones);
        end
        sb.delete();
        do_access(1'b0, 1'b0, 4'd1, 8'h00);
    endtask

    task automatic test_out_of_range();
        do_access(1'b1, 1'b1, 4'd5, 8'h77);
        do_access(1'b1, 1'b0, 4'd5, 8'h00);
        do_access(1'b1, 1'b1, 4'd13, 8'hFF);
        do_access(1'b1, 1'b0, 4'd13, 8'h00);
        do_access(1'b1, 1'b0, 4'd11, 8'h00);
    endtask

    task automatic test_reset_mid_access();
        int cnt, w;
        do_access(1'b0, 1'b1, 4'd6, 8'hC3);
        do_access(1'b0, 1'b0, 4'd6, 8'h00);
        @(negedge clk);
        sel = 1'b0; op = 1'b1; addr = 4'd7; din = 8'h5A; req = 1'b1;
        w = 0;
        while (rdy !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_a.done !== 1'b0 || bus_a.ready !== 1'b0 || bus_a.data_out !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_state: done=%b ready=%b data_out=%h required 0/0/00",
                     bus_a.done, bus_a.ready, bus_a.data_out);
        end
        rst_n = 1'b1;
        model_clear();
        count_init(cnt);
        do_access(1'b0, 1'b0, 4'd7, 8'h00);
        do_access(1'b0, 1'b0, 4'd6, 8'h00);
    endtask

`ifdef MEMORY_ARRAY_PARITY_EN
    task automatic test_parity();
        do_access(1'b0, 1'b1, 4'd2, 8'h01);
        @(negedge clk);
        dut_a.par_mem[2] = ~dut_a.par_mem[2];
        exp_perr = 1'b1;
        do_access(1'b0, 1'b0, 4'd2, 8'h00);
        exp_perr = 1'b0;
        do_access(1'b0, 1'b1, 4'd4, 8'h03);
        do_access(1'b0, 1'b0, 4'd4, 8'h00);
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_access();
`ifdef MEMORY_ARRAY_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
